// File: rtl/pipeline_pkg.sv
// Shared types for the elastic pipeline register family.
package pipeline_pkg;

   // Occupancy of the elastic buffer: nothing held, main entry held,
   // or main plus skid entries held.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_FULL  = 2'd1,
      BUF_SKID  = 2'd2
   } pipe_buf_state_t;

endpackage : pipeline_pkg

// File: rtl/pipeline_elastic_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   // Next count: clear first, otherwise step unless already at all-ones.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_elastic_reg.sv
// Elastic pipeline register: valid/ready stage with optional two-entry skid
// buffer, flush/hold hazard controls and bubble/stall performance counters.
//
// Handshake: a beat moves upstream when in_valid && in_ready and downstream
// when out_valid && out_ready, both on the rising edge of CLK. A producer
// must hold in_data stable while in_valid is high and not accepted; out_data
// is stable while out_valid is high and not accepted (unless flushed).
module pipeline_elastic_reg
   import pipeline_pkg::*;
#(
   parameter int WIDTH          = 64,
   parameter int SKID           = 1,
   parameter int CLEAR_ON_FLUSH = 1,
   parameter int CNT_W          = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             hold,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             clr_cnt,
   output pipe_buf_state_t  dbg_state
);

   pipe_buf_state_t  state_d, state_q;
   logic [WIDTH-1:0] main_d_d, main_d_q;
   logic [WIDTH-1:0] skid_d_d, skid_d_q;
   logic             rst_done_d, rst_done_q;

   logic main_v;
   logic skid_v;
   logic accept;
   logic emit;

   // Valid bits are decoded from the occupancy state.
   assign main_v = (state_q != BUF_EMPTY);
   assign skid_v = (state_q == BUF_SKID);

   // Ready: with a skid buffer it depends on registered state only, which
   // cuts the out_ready -> in_ready path; without one it passes through.
   // rst_done_q keeps it low until the first edge after reset release.
   always_comb begin
      in_ready = 1'b0;
      if (SKID != 0) begin
         in_ready = !skid_v && !hold && !flush && rst_done_q;
      end else begin
         in_ready = (!main_v || out_ready) && !hold && !flush && rst_done_q;
      end
   end

   assign out_valid = main_v && !hold;
   assign out_data  = main_d_q;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;
   assign dbg_state = state_q;
   assign rst_done_d = 1'b1;

   // Next state and payload: flush beats hold beats the handshake.
   always_comb begin
      state_d  = state_q;
      main_d_d = main_d_q;
      skid_d_d = skid_d_q;
      if (flush) begin
         state_d = BUF_EMPTY;
         if (CLEAR_ON_FLUSH != 0) begin
            main_d_d = '0;
            skid_d_d = '0;
         end
      end else if (!hold) begin
         unique case (state_q)
            BUF_EMPTY: begin
               if (accept) begin
                  state_d  = BUF_FULL;
                  main_d_d = in_data;
               end
            end
            BUF_FULL: begin
               if (accept && emit) begin
                  main_d_d = in_data;
               end else if (accept) begin
                  // Only reachable with a skid buffer; without one,
                  // accepting while full implies a same-cycle emit.
                  if (SKID != 0) begin
                     state_d  = BUF_SKID;
                     skid_d_d = in_data;
                  end
               end else if (emit) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_SKID: begin
               if (emit) begin
                  state_d  = BUF_FULL;
                  main_d_d = skid_d_q;
               end
            end
            default: begin
               state_d = BUF_EMPTY;
            end
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= BUF_EMPTY;
         main_d_q   <= '0;
         skid_d_q   <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_d_q   <= main_d_d;
         skid_d_q   <= skid_d_d;
         rst_done_q <= rst_done_d;
      end
   end

   // Bubble: no valid beat offered (hold counts, since out_valid is gated).
   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (!out_valid),
      .clr   (clr_cnt),
      .count (bubble_cnt)
   );

   // Stall: beat offered but downstream not accepting.
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (out_valid && !out_ready),
      .clr   (clr_cnt),
      .count (stall_cnt)
   );

endmodule : pipeline_elastic_reg

// File: tb/tb_pipeline_elastic_reg.sv
// Directed bench for pipeline_elastic_reg (WIDTH=64, SKID=1, CNT_W=4).
module tb_pipeline_elastic_reg;
   import pipeline_pkg::*;

   localparam int WIDTH = 64;
   localparam int CNT_W = 4;

   logic             CLK;
   logic             nRST;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic             hold;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             clr_cnt;
   pipe_buf_state_t  dbg_state;

   int n_checks;
   int n_fail;

   pipeline_elastic_reg #(
      .WIDTH(WIDTH), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(CNT_W)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .flush      (flush),
      .hold       (hold),
      .bubble_cnt (bubble_cnt),
      .stall_cnt  (stall_cnt),
      .clr_cnt    (clr_cnt),
      .dbg_state  (dbg_state)
   );

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nRST = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b1;
      flush = 1'b0; hold = 1'b0; clr_cnt = 1'b0;

      // ---------------- reset ----------------
      repeat (3) step();
      settle();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_bubble", bubble_cnt, 0);
      check_eq("rst_stall", stall_cnt, 0);
      check_eq("rst_in_ready", in_ready, 0);
      in_valid = 1'b0;
      #1 nRST = 1'b1;
      settle();
      check_eq("rel_in_ready_pre_edge", in_ready, 0);
      step();
      check_eq("rel_in_ready", in_ready, 1);
      check_eq("rel_state", dbg_state, BUF_EMPTY);

      // ---------------- streaming 1..8 ----------------
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 64'(i);
         settle();
         check_eq($sformatf("str_in_ready_%0d", i), in_ready, 1);
         check_eq($sformatf("str_out_valid_%0d", i), out_valid, (i > 1) ? 1 : 0);
         if (i > 1) check_eq($sformatf("str_out_data_%0d", i), out_data, 64'(i - 1));
         step();
      end
      in_valid = 1'b0;
      settle();
      check_eq("str_out_valid_last", out_valid, 1);
      check_eq("str_out_data_last", out_data, 8);
      check_eq("str_bubble_const", bubble_cnt, 1);
      check_eq("str_stall", stall_cnt, 0);
      step();
      check_eq("str_drained", out_valid, 0);

      // ---------------- backpressure ----------------
      out_ready = 1'b0; clr_cnt = 1'b1;
      in_valid = 1'b1; in_data = 64'hA;
      settle();
      check_eq("bp_rdy_a", in_ready, 1);
      step();
      clr_cnt = 1'b0; in_data = 64'hB;
      settle();
      check_eq("bp_rdy_b", in_ready, 1);
      check_eq("bp_data_b", out_data, 64'hA);
      check_eq("bp_stall_b", stall_cnt, 0);
      step();
      in_data = 64'hC;
      settle();
      check_eq("bp_rdy_c", in_ready, 0);
      check_eq("bp_state_c", dbg_state, BUF_SKID);
      check_eq("bp_stall_c", stall_cnt, 1);
      step();
      check_eq("bp_stall_c2", stall_cnt, 2);
      check_eq("bp_data_c2", out_data, 64'hA);
      out_ready = 1'b1;
      settle();
      check_eq("bp_r1_rdy", in_ready, 0);
      check_eq("bp_r1_data", out_data, 64'hA);
      step();
      check_eq("bp_r2_rdy", in_ready, 1);
      check_eq("bp_r2_data", out_data, 64'hB);
      step();
      in_valid = 1'b0;
      settle();
      check_eq("bp_r3_valid", out_valid, 1);
      check_eq("bp_r3_data", out_data, 64'hC);
      step();
      check_eq("bp_r4_valid", out_valid, 0);

      // ---------------- flush in SKID ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'h11;
      step();
      in_data = 64'h22;
      step();
      in_valid = 1'b0;
      check_eq("fl_state", dbg_state, BUF_SKID);
      flush = 1'b1;
      settle();
      check_eq("fl_in_ready", in_ready, 0);
      step();
      flush = 1'b0; out_ready = 1'b1;
      settle();
      check_eq("fl_out_valid", out_valid, 0);
      check_eq("fl_out_data", out_data, 0);
      check_eq("fl_in_ready_after", in_ready, 1);
      in_valid = 1'b1; in_data = 64'h33;
      step();
      in_valid = 1'b0;
      settle();
      check_eq("fl_next_valid", out_valid, 1);
      check_eq("fl_next_data", out_data, 64'h33);
      step();

      // ---------------- hold 3 cycles ----------------
      in_valid = 1'b1; in_data = 64'h55; clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0; hold = 1'b1; in_data = 64'h66;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq($sformatf("hold_valid_%0d", i), out_valid, 0);
         check_eq($sformatf("hold_rdy_%0d", i), in_ready, 0);
         step();
      end
      hold = 1'b0;
      settle();
      check_eq("hold_bubble", bubble_cnt, 3);
      check_eq("hold_rel_valid", out_valid, 1);
      check_eq("hold_rel_data", out_data, 64'h55);
      check_eq("hold_rel_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      settle();
      check_eq("hold_next_data", out_data, 64'h66);
      step();

      // ---------------- counter saturation ----------------
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      repeat (20) step();
      check_eq("sat_bubble", bubble_cnt, 15);
      clr_cnt = 1'b1;
      step();
      check_eq("sat_clr", bubble_cnt, 0);
      step();
      check_eq("sat_clr_vs_inc", bubble_cnt, 0);
      clr_cnt = 1'b0;
      step();
      check_eq("sat_recount", bubble_cnt, 1);

      // ---------------- async reset mid-transfer ----------------
      in_valid = 1'b1; in_data = 64'h77;
      step();
      in_valid = 1'b0;
      settle();
      check_eq("ar_pre_valid", out_valid, 1);
      nRST = 1'b0;
      settle();
      check_eq("ar_out_valid", out_valid, 0);
      check_eq("ar_out_data", out_data, 0);
      check_eq("ar_bubble", bubble_cnt, 0);
      check_eq("ar_in_ready", in_ready, 0);
      step();
      nRST = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipeline_elastic_reg
